// File: rtl/bdc_pkg.sv
// rtl/bdc_pkg.sv - shared state encoding and port-width helper for the frame sequencer
package bdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  // clog2 that never collapses to a zero-width vector
  function automatic int bdc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bdc_raster_cnt.sv
// rtl/bdc_raster_cnt.sv - raster x/y position counter with clear-and-step, wrap and last flags
module bdc_raster_cnt #(
  parameter int XN = 4,
  parameter int YN = 8,
  parameter int XW = 2,
  parameter int YW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [YW-1:0] y_nxt,
  output logic          at_last,
  output logic          wrap,
  output logic          done
);

  logic [XW-1:0] xb;
  logic [YW-1:0] yb;
  logic [XW-1:0] x_nxt;
  logic          xb_last;
  logic          yb_last;

  // clr restarts at (0,0); clr together with en leaves the counter one step past (0,0)
  always_comb begin
    xb      = clr ? '0 : x;
    yb      = clr ? '0 : y;
    xb_last = (xb == XW'(XN - 1));
    yb_last = (yb == YW'(YN - 1));
    wrap    = en && xb_last;
    done    = wrap && yb_last;
    x_nxt   = xb;
    y_nxt   = yb;
    if (en) begin
      if (xb_last) begin
        x_nxt = '0;
        y_nxt = yb_last ? '0 : yb + 1'b1;
      end else begin
        x_nxt = xb + 1'b1;
      end
    end
  end

  assign at_last = (x == XW'(XN - 1)) && (y == YW'(YN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/bdc_frame_sequencer.sv
// rtl/bdc_frame_sequencer.sv - line-buffer write / output-coordinate sequencer; BDC_SEQ_STATS_EN adds frame_cnt/drop_cnt
module bdc_frame_sequencer
  import bdc_pkg::*;
#(
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int LOOKAHEAD      = 16,
  parameter int LINE_BUF_LINES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tuser,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic                                 wr_en,
  output logic [bdc_width(WIDTH)-1:0]          wr_x,
  output logic [bdc_width(LINE_BUF_LINES)-1:0] wr_slot,
  output logic                                 coord_valid,
  input  logic                                 coord_ready,
  output logic [bdc_width(WIDTH)-1:0]          coord_x,
  output logic [bdc_width(HEIGHT)-1:0]         coord_y,
  output logic                                 coord_sof,
  output logic                                 coord_eof,
  output logic                                 frame_done,
  output logic                                 sof_err,
  output logic                                 len_err
`ifdef BDC_SEQ_STATS_EN
  ,
  output logic [15:0]                          frame_cnt,
  output logic [15:0]                          drop_cnt
`endif
);

  localparam int XW = bdc_width(WIDTH);
  localparam int YW = bdc_width(HEIGHT);
  localparam int SW = bdc_width(LINE_BUF_LINES);

  if (LINE_BUF_LINES < 2 * LOOKAHEAD + 2) begin : g_bad_cfg
    $error("bdc_frame_sequencer: LINE_BUF_LINES must be at least 2*LOOKAHEAD+2");
  end

  seq_state_t    state, state_d;
  logic          accept, restart, write, xfer, c_en;
  logic [XW-1:0] in_x, ox;
  logic [YW-1:0] in_y, in_y_nxt, oy, oy_nxt;
  logic          w_wrap, w_done, w_at_last;
  logic          c_wrap, c_done, c_at_last;
  logic [SW-1:0] slot, slot_d;
  logic          valid_q, valid_d, done_q, sof_err_q, len_err_q;
  int            rows_cur, rows_nxt;
  logic          unused_ok;

  // row oy may be emitted once its lookahead window is fully written
  function automatic logic issuable(input int rows, input int row);
    int need;
    need = row + LOOKAHEAD + 1;
    if (need > HEIGHT) need = HEIGHT;
    return rows >= need;
  endfunction

  // writing row `rows` must not overwrite the oldest row still reachable from row oy
  function automatic logic has_room(input int rows, input int row);
    int lo;
    lo = row - LOOKAHEAD;
    if (lo < 0) lo = 0;
    return rows < lo + LINE_BUF_LINES;
  endfunction

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign restart = accept && s_axis_tuser;
  assign write   = accept && ((state != ST_IDLE) || s_axis_tuser);
  assign xfer    = coord_valid && coord_ready;
  assign c_en    = xfer && !restart;

  bdc_raster_cnt #(.XN(WIDTH), .YN(HEIGHT), .XW(XW), .YW(YW)) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (restart),
    .en      (write),
    .x       (in_x),
    .y       (in_y),
    .y_nxt   (in_y_nxt),
    .at_last (w_at_last),
    .wrap    (w_wrap),
    .done    (w_done)
  );

  bdc_raster_cnt #(.XN(WIDTH), .YN(HEIGHT), .XW(XW), .YW(YW)) u_coord_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (restart),
    .en      (c_en),
    .x       (ox),
    .y       (oy),
    .y_nxt   (oy_nxt),
    .at_last (c_at_last),
    .wrap    (c_wrap),
    .done    (c_done)
  );

  assign unused_ok = ^{w_at_last, c_wrap};

  // the write counter wraps to (0,0) after the last pixel, so completed rows saturate at HEIGHT
  assign rows_cur = (state == ST_DRAIN) ? HEIGHT : int'(in_y);
  assign rows_nxt = (w_done || state == ST_DRAIN) ? HEIGHT : int'(in_y_nxt);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (restart) state_d = w_done ? ST_DRAIN : ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        if (write && w_done)                                 state_d = ST_DRAIN;
        else if (restart)                                    state_d = ST_FILL;
        else if (state == ST_FILL && issuable(rows_nxt, 0))  state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (c_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      ST_IDLE:         s_axis_tready = 1'b1;
      ST_FILL, ST_RUN: s_axis_tready = has_room(rows_cur, int'(oy));
      default:         s_axis_tready = 1'b0;
    endcase
    if (rst) s_axis_tready = 1'b0;
    coord_valid = valid_q && !rst;
    coord_x     = rst ? '0 : ox;
    coord_y     = rst ? '0 : oy;
    coord_sof   = valid_q && !rst && (ox == '0) && (oy == '0);
    coord_eof   = valid_q && !rst && c_at_last;
    frame_done  = done_q && !rst;
    sof_err     = sof_err_q && !rst;
    len_err     = len_err_q && !rst;
  end

  // a start-of-frame beat always lands at column 0 of slot 0
  assign wr_en   = write;
  assign wr_x    = s_axis_tuser ? '0 : in_x;
  assign wr_slot = s_axis_tuser ? '0 : slot;

  always_comb begin
    slot_d = restart ? '0 : slot;
    if (w_wrap) slot_d = (slot_d == SW'(LINE_BUF_LINES - 1)) ? '0 : slot_d + 1'b1;
  end

  assign valid_d = (state_d != ST_IDLE) && issuable(rows_nxt, int'(oy_nxt));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      sof_err_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      slot      <= slot_d;
      valid_q   <= valid_d;
      done_q    <= c_done;
      sof_err_q <= restart && (state != ST_IDLE);
      len_err_q <= write && (s_axis_tlast != w_done);
    end
  end

`ifdef BDC_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (done_q && frame_cnt != 16'hffff) frame_cnt <= frame_cnt + 16'd1;
      if (accept && state == ST_IDLE && !s_axis_tuser && drop_cnt != 16'hffff)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bdc_frame_sequencer.sv
// tb/tb_bdc_frame_sequencer.sv - scenario table plus count-based reference model for bdc_frame_sequencer
module tb_bdc_frame_sequencer;

  localparam int W = 4, H = 8, LA = 1, LBL = 4, NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst, s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
  logic       wr_en, coord_valid, coord_ready, coord_sof, coord_eof;
  logic       frame_done, sof_err, len_err;
  logic [1:0] wr_x, wr_slot, coord_x;
  logic [2:0] coord_y;
`ifdef BDC_SEQ_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  bdc_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .LOOKAHEAD(LA), .LINE_BUF_LINES(LBL)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .wr_en(wr_en), .wr_x(wr_x), .wr_slot(wr_slot),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .coord_x(coord_x), .coord_y(coord_y), .coord_sof(coord_sof), .coord_eof(coord_eof),
    .frame_done(frame_done), .sof_err(sof_err), .len_err(len_err)
`ifdef BDC_SEQ_STATS_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    int junk; int beats; int sof_at; int tl_a; int tl_b; int rmode; int gap; int rst_after;
    int chk_first; int exp_done; int exp_sof; int exp_len; int exp_coords;
  } scen_t;

  int n_cmp = 0, n_bad = 0;
  // model: pixels written (m_k) and coordinates handed out (m_n) in the current frame
  bit m_in_frame;
  int m_k, m_n;
  bit p_done, p_sof, p_len, acc_s;
  int c_done, c_sof, c_len, c_coords, acc_frame, acc8_cyc, fval_cyc, cyc_no;
  bit s_rdy, s_val;
  int s_cx, s_cy;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic bit ready_val(input int rmode);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic step();
    bit e_rdy, e_val, e_wr, xf;
    int e_idx, lo, need;
    e_idx = 0;
    @(negedge clk);
    cyc_no++;
    s_rdy = s_axis_tready; s_val = coord_valid; s_cx = int'(coord_x); s_cy = int'(coord_y);
    if (rst) begin
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_valid", coord_valid, 0);
      chk("rst_coord_xy", int'(coord_x) + int'(coord_y), 0);
      chk("rst_markers", int'(coord_sof) + int'(coord_eof), 0);
      chk("rst_pulses", int'(frame_done) + int'(sof_err) + int'(len_err), 0);
      @(posedge clk);
      m_in_frame = 0; m_k = 0; m_n = 0; p_done = 0; p_sof = 0; p_len = 0; acc_s = 0;
      #1;
      return;
    end
    lo = m_n / W - LA; if (lo < 0) lo = 0;
    need = m_n / W + LA + 1; if (need > H) need = H;
    e_rdy = !m_in_frame ? 1'b1 : (m_k == NPIX) ? 1'b0 : ((m_k / W) < lo + LBL);
    e_val = m_in_frame && ((m_k / W) >= need);
    acc_s = s_axis_tvalid && e_rdy;
    e_wr  = acc_s && (m_in_frame || s_axis_tuser);
    chk("tready", s_axis_tready, int'(e_rdy));
    chk("wr_en", wr_en, int'(e_wr));
    if (e_wr) begin
      e_idx = s_axis_tuser ? 0 : m_k;
      chk("wr_x", int'(wr_x), e_idx % W);
      chk("wr_slot", int'(wr_slot), (e_idx / W) % LBL);
    end
    chk("coord_valid", coord_valid, int'(e_val));
    if (e_val) begin
      chk("coord_x", int'(coord_x), m_n % W);
      chk("coord_y", int'(coord_y), m_n / W);
      chk("coord_sof", coord_sof, int'(m_n == 0));
      chk("coord_eof", coord_eof, int'(m_n == NPIX - 1));
    end
    chk("frame_done", frame_done, int'(p_done));
    chk("sof_err", sof_err, int'(p_sof));
    chk("len_err", len_err, int'(p_len));
    if (frame_done) c_done++;
    if (sof_err) c_sof++;
    if (len_err) c_len++;
    if (coord_valid && coord_ready) c_coords++;
    if (coord_valid && fval_cyc < 0) fval_cyc = cyc_no;
    xf = e_val && coord_ready;
    p_done = 0; p_sof = 0;
    p_len = e_wr && (s_axis_tlast != (e_idx == NPIX - 1));
    if (acc_s && s_axis_tuser) begin
      p_sof = m_in_frame;
      m_in_frame = 1; m_k = 1; m_n = 0;
      acc_frame = 1; c_coords = 0; fval_cyc = -1; acc8_cyc = -1;
    end else begin
      if (e_wr) begin
        m_k++; acc_frame++;
        if (acc_frame == 8 && acc8_cyc < 0) acc8_cyc = cyc_no;
      end
      if (xf) begin
        m_n++;
        if (m_n == NPIX) begin m_in_frame = 0; p_done = 1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic drive_beats(input int first, input int last, input int sof_at,
                             input int tl_a, input int tl_b, input int rmode, input int gap);
    int b, cyc;
    b = first; cyc = 0;
    while (b <= last && cyc < 3000) begin
      s_axis_tvalid = ($urandom_range(0, 99) >= gap);
      s_axis_tuser  = (b == 1) || (b == sof_at);
      s_axis_tlast  = (b == tl_a) || (b == tl_b);
      coord_ready   = ready_val(rmode);
      step();
      if (acc_s) b++;
      cyc++;
    end
    chk("beat_bound", b, last + 1);
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
  endtask

  task automatic wait_done(input int rmode);
    int cyc;
    cyc = 0;
    while (m_in_frame && cyc < 600) begin
      coord_ready = ready_val(rmode);
      step();
      cyc++;
    end
    chk("drain_bound", int'(m_in_frame), 0);
    coord_ready = 1;
    repeat (3) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    scen_t tbl [7];
`ifdef BDC_SEQ_STATS_EN
    int fc0, dc0;
`endif
    tbl[0] = '{3, 32,  0, 32, 0, 0,  0, 0, 1, 1, 0, 0, 32};
    tbl[1] = '{0, 32,  0, 32, 0, 1, 30, 0, 0, 1, 0, 0, 32};
    tbl[2] = '{0, 41, 10, 41, 0, 1, 20, 0, 0, 1, 1, 0, 32};
    tbl[3] = '{0, 32,  0, 20, 0, 0, 10, 0, 0, 1, 0, 2, 32};
    tbl[4] = '{0, 12,  0,  0, 0, 1,  0, 1, 0, 0, 0, 0, -1};
    tbl[5] = '{2, 32,  0, 32, 0, 1,  0, 0, 0, 1, 0, 0, 32};
    tbl[6] = '{1, 32,  0, 32, 0, 1, 50, 0, 0, 1, 0, 0, 32};

    cyc_no = 0; acc8_cyc = -1; fval_cyc = -1; acc_frame = 0;
    coord_ready = 1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      c_done = 0; c_sof = 0; c_len = 0; c_coords = 0;
`ifdef BDC_SEQ_STATS_EN
      fc0 = int'(frame_cnt); dc0 = int'(drop_cnt);
`endif
      for (int j = 0; j < tbl[i].junk; j++) begin
        s_axis_tvalid = 1; s_axis_tuser = 0; s_axis_tlast = 0;
        step();
      end
      drive_beats(1, tbl[i].beats, tbl[i].sof_at, tbl[i].tl_a, tbl[i].tl_b, tbl[i].rmode, tbl[i].gap);
      if (tbl[i].rst_after != 0) begin
        rst = 1; step(); rst = 0;
        repeat (4) step();
      end else begin
        wait_done(tbl[i].rmode);
      end
      chk($sformatf("s%0d_frame_done_cnt", i), c_done, tbl[i].exp_done);
      chk($sformatf("s%0d_sof_err_cnt", i), c_sof, tbl[i].exp_sof);
      chk($sformatf("s%0d_len_err_cnt", i), c_len, tbl[i].exp_len);
      if (tbl[i].exp_coords >= 0) chk($sformatf("s%0d_coords", i), c_coords, tbl[i].exp_coords);
      if (tbl[i].chk_first != 0) chk("first_valid_after_8th_beat", fval_cyc, acc8_cyc + 1);
`ifdef BDC_SEQ_STATS_EN
      chk($sformatf("s%0d_frame_cnt", i), int'(frame_cnt), (tbl[i].rst_after != 0) ? 0 : fc0 + tbl[i].exp_done);
      chk($sformatf("s%0d_drop_cnt", i), int'(drop_cnt), (tbl[i].rst_after != 0) ? 0 : dc0 + tbl[i].junk);
`endif
    end

    // back-pressure: with no coordinate consumer the input stalls once the buffer is full
    do_reset();
    c_done = 0;
    drive_beats(1, 16, 0, 0, 0, 2, 0);
    s_axis_tvalid = 1; s_axis_tuser = 0; s_axis_tlast = 0;
    for (int k = 0; k < 4; k++) begin
      coord_ready = 0;
      step();
      chk("stall_tready", int'(s_rdy), 0);
      chk("stall_valid", int'(s_val), 1);
      chk("stall_coord_x", s_cx, 0);
      chk("stall_coord_y", s_cy, 0);
    end
    s_axis_tvalid = 0;
    drive_beats(17, 32, 0, 32, 0, 0, 0);
    wait_done(0);
    chk("stall_frame_done_cnt", c_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bdc_frame_sequencer.md
BDC_FRAME_SEQUENCER -- requirements
Module: bdc_frame_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, image height in lines.
REQ-003 SHALL have parameter LOOKAHEAD, default 16, maximum vertical source displacement in lines.
REQ-004 SHALL have parameter LINE_BUF_LINES, default 64, line-buffer slots; SHALL be at least 2*LOOKAHEAD+2 (elaboration error otherwise).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports s_axis_tvalid, s_axis_tuser, s_axis_tlast, each input, 1, upstream pixel handshake, SOF marker and EOF marker (last pixel of frame).
REQ-008 SHALL have port s_axis_tready, output, 1, upstream accept.
REQ-009 SHALL have ports wr_en (output, 1), wr_x (output, clog2(WIDTH)) and wr_slot (output, clog2(LINE_BUF_LINES)), line-buffer write strobe, column and slot (row mod LINE_BUF_LINES).
REQ-010 SHALL have ports coord_valid (output, 1) and coord_ready (input, 1), output-coordinate handshake to the correction engine.
REQ-011 SHALL have ports coord_x (output, clog2(WIDTH)), coord_y (output, clog2(HEIGHT)), coord_sof (output, 1) and coord_eof (output, 1), output raster position and frame markers.
REQ-012 SHALL have ports frame_done, sof_err and len_err, each output, 1, single-cycle status pulses.

Function
REQ-013 SHALL implement states IDLE, FILL, RUN and DRAIN.
REQ-014 IDLE: s_axis_tready=1; beats with tuser=0 are discarded; a beat with tuser=1 is written at (0,0) and the FSM moves to FILL.
REQ-015 Accepted beat (tvalid&&tready) SHALL drive wr_en=1 combinationally with the current wr_x/wr_slot; column wraps at WIDTH-1 and increments rows_done.
REQ-016 Output row oy SHALL be issuable only when rows_done >= min(oy+LOOKAHEAD+1, HEIGHT).
REQ-017 FILL->RUN when row 0 becomes issuable; coord_valid SHALL assert one cycle after the condition becomes true (registered).
REQ-018 s_axis_tready SHALL be 1 in FILL/RUN only while in_row < max(oy-LOOKAHEAD,0)+LINE_BUF_LINES, and SHALL be 0 in DRAIN.
REQ-019 Coordinates SHALL advance raster-order on coord_valid&&coord_ready and hold stable while coord_valid&&!coord_ready.
REQ-020 coord_sof=1 only at (0,0); coord_eof=1 only at (WIDTH-1,HEIGHT-1).
REQ-021 After the last input pixel is accepted, FSM SHALL enter DRAIN; on the coord_eof transfer it SHALL pulse frame_done and return to IDLE.
REQ-022 tuser=1 on an accepted beat outside IDLE SHALL pulse sof_err, restart both counters with that pixel at (0,0), clear coord_valid, and enter FILL.
REQ-023 tlast on a non-final pixel, or missing tlast on the final pixel, SHALL pulse len_err; the frame SHALL continue unaltered by position count.

Reset
REQ-024 On rst, SHALL enter IDLE, clear all counters, and drive coord_valid, wr_en, frame_done, sof_err, len_err, coord_sof and coord_eof to 0, coord_x/coord_y to 0, and s_axis_tready to 0 during the reset cycle.
REQ-025 Reset mid-frame SHALL abandon the frame without a frame_done pulse.

Configuration
REQ-026 With BDC_SEQ_STATS_EN defined, SHALL add outputs frame_cnt[15:0] (incremented on frame_done) and drop_cnt[15:0] (incremented on each IDLE-discarded beat), both saturating and cleared by rst; without it, SHALL have no such ports or logic.

Structure
REQ-027 Package bdc_pkg SHALL hold the state enum and a width-helper function; no other shared constants.
REQ-028 SHALL instantiate sub-module bdc_raster_cnt (x/y counter with wrap and last flags) twice: write side and coordinate side.

Verification (WIDTH=4, HEIGHT=8, LOOKAHEAD=1, LINE_BUF_LINES=4)
REQ-029 SHALL cover: 32-pixel frame, coord_ready=1 -> first coord_valid the cycle after the 8th accepted beat, 32 coords raster-order, one frame_done.
REQ-030 SHALL cover: coord_ready=0 -> s_axis_tready falls after exactly 16 accepted beats, coord_x/coord_y hold 0/0.
REQ-031 SHALL cover: 3 beats with tuser=0 in IDLE -> no wr_en, drop_cnt=3 when the macro is defined.
REQ-032 SHALL cover: tuser=1 on beat 10 -> sof_err pulse, that beat written wr_x=0 wr_slot=0, frame completes 32 coords later.
REQ-033 SHALL cover: tlast on beat 20 and absent on beat 32 -> two len_err pulses, frame_done still asserted.
REQ-034 SHALL cover: rst asserted after 12 beats -> IDLE, coord_valid=0, no frame_done; next SOF frame completes normally.
